module_wr_dmux_n: RTL and testbench



---
 rtl/module_wr_dmux_n_pkg.sv | 21 ++
 rtl/module_wr_dmux_n_if.sv | 36 +++
 rtl/module_wr_dmux_n_edge_det.sv | 22 ++
 rtl/module_wr_dmux_n.sv | 148 ++++++++++++++
 tb/tb_module_wr_dmux_n.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/module_wr_dmux_n_pkg.sv
// Shared types and constants for the N-channel write router.
//   state_e   : router FSM states
//   ERR_*     : err_code_o encodings
//   sel_w()   : width of a channel index for n channels (at least 1)
package wr_dmux_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RELEASE = 2'd2
    } state_e;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_RANGE = 2'b01;
    localparam logic [1:0] ERR_TMO   = 2'b10;

    function automatic int unsigned sel_w(input int unsigned n);
        return (n > 1) ? int'($clog2(n)) : 1;
    endfunction

endpackage

// File: rtl/module_wr_dmux_n_if.sv
// Host/channel bundle of the write router.
//   wr_i, reg_sel_i, data_i, ack_i, err_clr_i : requests into the router
//   wr_o, data_o, busy_o, done_o, err_o, err_code_o : router results
// slave = router side, master = host/channel side.
interface module_wr_dmux_n_if
    import wr_dmux_pkg::*;
#(
    parameter int unsigned N_CH   = 4,
    parameter int unsigned DATA_W = 8
) ();

    localparam int unsigned SEL_W = sel_w(N_CH);

    logic              wr_i;
    logic [SEL_W-1:0]  reg_sel_i;
    logic [DATA_W-1:0] data_i;
    logic [N_CH-1:0]   ack_i;
    logic              err_clr_i;
    logic [N_CH-1:0]   wr_o;
    logic [DATA_W-1:0] data_o;
    logic              busy_o;
    logic              done_o;
    logic              err_o;
    logic [1:0]        err_code_o;

    modport slave (
        input  wr_i, reg_sel_i, data_i, ack_i, err_clr_i,
        output wr_o, data_o, busy_o, done_o, err_o, err_code_o
    );

    modport master (
        output wr_i, reg_sel_i, data_i, ack_i, err_clr_i,
        input  wr_o, data_o, busy_o, done_o, err_o, err_code_o
    );

endinterface

// File: rtl/module_wr_dmux_n_edge_det.sv
// Rising-edge detector: remembers d_i from the previous clock edge.
//   clk_i    : clock
//   rst_i    : async active-high reset (history cleared to 0)
//   d_i      : level input
//   rise_c_o : combinational, high while d_i=1 and it was 0 at the last edge
module module_edge_det (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic rise_c_o
);

    logic d_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) d_q <= 1'b0;
        else       d_q <= d_i;
    end

    assign rise_c_o = d_i & ~d_q;

endmodule

// File: rtl/module_wr_dmux_n.sv
// N-channel write router between the SPI command decoder and register blocks.
// Accepts a host write, drives a registered one-hot strobe plus held data to
// the selected channel until it acks (or a timeout fires), flags bad selects.
//   clk_i, rst_i : clock, async active-high reset
//   bus (slave)  : wr_i/reg_sel_i/data_i/ack_i/err_clr_i in,
//                  wr_o/data_o/busy_o/done_o/err_o/err_code_o out
module module_wr_dmux_n
    import wr_dmux_pkg::*;
#(
    parameter int unsigned N_CH       = 4,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned TIMEOUT    = 15,
    parameter int unsigned PULSE_MODE = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    module_wr_dmux_n_if.slave     bus
);

    localparam int unsigned SEL_W = sel_w(N_CH);
    localparam int unsigned CNT_W = (TIMEOUT > 0) ? int'($clog2(TIMEOUT + 1)) : 1;

    state_e            state_q, state_d;
    logic [N_CH-1:0]   wr_q, wr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [1:0]        code_q, code_d;

    logic   wr_rise_c;
    logic   accept_c;
    logic   in_range_c;
    logic   ack_hit_c;
    logic   tmo_c;
    logic   err_set_c;
    logic   [1:0] err_new_c;
    state_e exit_c;

    module_edge_det u_edge (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .d_i      (bus.wr_i),
        .rise_c_o (wr_rise_c)
    );

    // State and output registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            wr_q    <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= ERR_NONE;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            code_q  <= code_d;
        end
    end

    // Next-state, strobe decode, timeout and error bookkeeping
    always_comb begin
        state_d   = state_q;
        wr_d      = wr_q;
        data_d    = data_q;
        cnt_d     = '0;
        done_d    = 1'b0;
        err_set_c = 1'b0;
        err_new_c = ERR_NONE;
        err_d     = err_q;
        code_d    = code_q;

        accept_c   = bus.wr_i && ((PULSE_MODE == 0) || wr_rise_c);
        in_range_c = 32'(bus.reg_sel_i) < N_CH;
        // wr_q is the captured one-hot select, so masking ack_i picks the
        // selected channel's ack and ignores every other channel.
        ack_hit_c  = |(bus.ack_i & wr_q);
        // cnt_q counts ISSUE edges already taken; the TIMEOUT-th edge fires.
        tmo_c      = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));
        // A write request still held after completion parks in RELEASE.
        exit_c     = ((PULSE_MODE != 0) && bus.wr_i) ? RELEASE : IDLE;

        unique case (state_q)
            IDLE: begin
                if (accept_c) begin
                    if (in_range_c) begin
                        wr_d    = N_CH'(1) << bus.reg_sel_i;
                        data_d  = bus.data_i;
                        state_d = ISSUE;
                    end else begin
                        err_set_c = 1'b1;
                        err_new_c = ERR_RANGE;
                        state_d   = (PULSE_MODE != 0) ? RELEASE : IDLE;
                    end
                end
            end
            ISSUE: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (ack_hit_c) begin
                    wr_d    = '0;
                    done_d  = 1'b1;
                    state_d = exit_c;
                end else if (tmo_c) begin
                    wr_d      = '0;
                    err_set_c = 1'b1;
                    err_new_c = ERR_TMO;
                    state_d   = exit_c;
                end
            end
            RELEASE: begin
                if (!bus.wr_i) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                wr_d    = '0;
            end
        endcase

        // A new error beats a clear; the first code sticks until cleared.
        if (err_set_c) begin
            err_d = 1'b1;
            if (!err_q || bus.err_clr_i) code_d = err_new_c;
        end else if (bus.err_clr_i) begin
            err_d  = 1'b0;
            code_d = ERR_NONE;
        end

        busy_d = (state_d != IDLE);
    end

    assign bus.wr_o       = wr_q;
    assign bus.data_o     = data_q;
    assign bus.busy_o     = busy_q;
    assign bus.done_o     = done_q;
    assign bus.err_o      = err_q;
    assign bus.err_code_o = code_q;

endmodule

// File: tb/tb_module_wr_dmux_n.sv
// Directed bench for module_wr_dmux_n: three instances
//   a: N_CH=4 pulse mode, b: N_CH=4 level mode, c: N_CH=3 pulse mode.
module tb_module_wr_dmux_n;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    module_wr_dmux_n_if #(.N_CH(4), .DATA_W(8)) if_a ();
    module_wr_dmux_n_if #(.N_CH(4), .DATA_W(8)) if_b ();
    module_wr_dmux_n_if #(.N_CH(3), .DATA_W(8)) if_c ();

    module_wr_dmux_n #(.N_CH(4), .DATA_W(8), .TIMEOUT(15), .PULSE_MODE(1)) dut_a (
        .clk_i(clk), .rst_i(rst), .bus(if_a.slave));
    module_wr_dmux_n #(.N_CH(4), .DATA_W(8), .TIMEOUT(15), .PULSE_MODE(0)) dut_b (
        .clk_i(clk), .rst_i(rst), .bus(if_b.slave));
    module_wr_dmux_n #(.N_CH(3), .DATA_W(8), .TIMEOUT(15), .PULSE_MODE(1)) dut_c (
        .clk_i(clk), .rst_i(rst), .bus(if_c.slave));

    typedef struct {
        logic       wr;
        logic [1:0] sel;
        logic [7:0] data;
        logic [3:0] ack;
        logic       clr;
        logic [3:0] e_wr;
        logic [7:0] e_data;
        logic       e_busy;
        logic       e_done;
        logic       e_err;
        logic [1:0] e_code;
    } vec_t;

    vec_t vecs[12];

    function automatic vec_t mk(input logic wr, input logic [1:0] sel, input logic [7:0] data,
                                input logic [3:0] ack, input logic clr, input logic [3:0] e_wr,
                                input logic [7:0] e_data, input logic e_busy, input logic e_done,
                                input logic e_err, input logic [1:0] e_code);
        vec_t v;
        v.wr = wr; v.sel = sel; v.data = data; v.ack = ack; v.clr = clr;
        v.e_wr = e_wr; v.e_data = e_data; v.e_busy = e_busy; v.e_done = e_done;
        v.e_err = e_err; v.e_code = e_code;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] out_a();
        return 32'({if_a.wr_o, if_a.data_o, if_a.busy_o, if_a.done_o, if_a.err_o, if_a.err_code_o});
    endfunction

    // One write to channel 1 of dut_a; clear/ack optionally asserted on edge N after issue.
    task automatic issue_sel1(input int clr_edge, input int ack_edge, output int hi, output int dones);
        if_a.wr_i = 1'b1; if_a.reg_sel_i = 2'd1; if_a.data_i = 8'hC3;
        tick();
        if_a.wr_i = 1'b0;
        hi    = (if_a.wr_o == 4'b0010) ? 1 : 0;
        dones = 0;
        for (int e = 1; e <= 40; e++) begin
            if_a.err_clr_i = (e == clr_edge);
            if_a.ack_i     = (e == ack_edge) ? 4'b0010 : 4'b0000;
            tick();
            dones += int'(if_a.done_o);
            if (if_a.wr_o == 4'b0010) hi++;
            else break;
        end
        if_a.err_clr_i = 1'b0;
        if_a.ack_i     = 4'b0000;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

    initial begin
        int n_a, n_b, hi, dones, multi;

        if_a.wr_i = 0; if_a.reg_sel_i = '0; if_a.data_i = '0; if_a.ack_i = '0; if_a.err_clr_i = 0;
        if_b.wr_i = 0; if_b.reg_sel_i = '0; if_b.data_i = '0; if_b.ack_i = '0; if_b.err_clr_i = 0;
        if_c.wr_i = 0; if_c.reg_sel_i = '0; if_c.data_i = '0; if_c.ack_i = '0; if_c.err_clr_i = 0;

        //              wr    sel    data   ack      clr    e_wr     e_data  busy  done  err   code
        vecs[0]  = mk(1'b1, 2'd2, 8'hA5, 4'b0000, 1'b0, 4'b0100, 8'hA5, 1'b1, 1'b0, 1'b0, 2'b00);
        vecs[1]  = mk(1'b0, 2'd1, 8'h3C, 4'b0000, 1'b0, 4'b0100, 8'hA5, 1'b1, 1'b0, 1'b0, 2'b00);
        vecs[2]  = mk(1'b0, 2'd1, 8'h3C, 4'b0100, 1'b0, 4'b0000, 8'hA5, 1'b0, 1'b1, 1'b0, 2'b00);
        vecs[3]  = mk(1'b0, 2'd0, 8'h00, 4'b0000, 1'b0, 4'b0000, 8'hA5, 1'b0, 1'b0, 1'b0, 2'b00);
        vecs[4]  = mk(1'b1, 2'd0, 8'h5A, 4'b0000, 1'b0, 4'b0001, 8'h5A, 1'b1, 1'b0, 1'b0, 2'b00);
        vecs[5]  = mk(1'b1, 2'd0, 8'h5A, 4'b1000, 1'b0, 4'b0001, 8'h5A, 1'b1, 1'b0, 1'b0, 2'b00);
        vecs[6]  = mk(1'b1, 2'd0, 8'h5A, 4'b0001, 1'b0, 4'b0000, 8'h5A, 1'b1, 1'b1, 1'b0, 2'b00);
        vecs[7]  = mk(1'b1, 2'd0, 8'h5A, 4'b0000, 1'b0, 4'b0000, 8'h5A, 1'b1, 1'b0, 1'b0, 2'b00);
        vecs[8]  = mk(1'b0, 2'd0, 8'h5A, 4'b0000, 1'b0, 4'b0000, 8'h5A, 1'b0, 1'b0, 1'b0, 2'b00);
        vecs[9]  = mk(1'b1, 2'd3, 8'hFF, 4'b0000, 1'b0, 4'b1000, 8'hFF, 1'b1, 1'b0, 1'b0, 2'b00);
        vecs[10] = mk(1'b0, 2'd3, 8'hFF, 4'b1000, 1'b0, 4'b0000, 8'hFF, 1'b0, 1'b1, 1'b0, 2'b00);
        vecs[11] = mk(1'b0, 2'd0, 8'h00, 4'b0000, 1'b1, 4'b0000, 8'hFF, 1'b0, 1'b0, 1'b0, 2'b00);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_a", out_a(), 32'h0);
        chk("reset_c", 32'({if_c.wr_o, if_c.data_o, if_c.busy_o, if_c.done_o, if_c.err_o, if_c.err_code_o}), 32'h0);
        rst = 1'b0;

        // Table: basic write, ignored select/data changes, wrong-channel ack, release
        for (int i = 0; i < 12; i++) begin
            if_a.wr_i = vecs[i].wr; if_a.reg_sel_i = vecs[i].sel; if_a.data_i = vecs[i].data;
            if_a.ack_i = vecs[i].ack; if_a.err_clr_i = vecs[i].clr;
            tick();
            chk($sformatf("vec%0d", i), out_a(),
                32'({vecs[i].e_wr, vecs[i].e_data, vecs[i].e_busy, vecs[i].e_done,
                     vecs[i].e_err, vecs[i].e_code}));
        end
        if_a.err_clr_i = 1'b0;

        // Held wr_i with prompt ack: pulse mode writes once, level mode every 2 cycles
        n_a = 0; n_b = 0; multi = 0;
        if_a.wr_i = 1'b1; if_a.reg_sel_i = 2'd2; if_a.data_i = 8'h11;
        if_b.wr_i = 1'b1; if_b.reg_sel_i = 2'd2; if_b.data_i = 8'h22;
        for (int k = 0; k < 20; k++) begin
            tick();
            n_a += int'(if_a.done_o);
            n_b += int'(if_b.done_o);
            if ($countones(if_b.wr_o) > 1) multi++;
            if_a.ack_i = if_a.wr_o;
            if_b.ack_i = if_b.wr_o;
        end
        if_a.wr_i = 1'b0; if_a.ack_i = '0;
        if_b.wr_i = 1'b0; if_b.ack_i = '0;
        tick();
        chk("held_pulse_dones", 32'(n_a), 32'd1);
        chk("held_level_dones", 32'(n_b), 32'd10);
        chk("level_onehot", 32'(multi), 32'd0);
        chk("held_pulse_idle", 32'(if_a.busy_o), 32'd0);

        // Out-of-range select on the 3-channel instance, then clear
        if_c.wr_i = 1'b1; if_c.reg_sel_i = 2'd3; if_c.data_i = 8'h77;
        tick();
        chk("oor_flags", 32'({if_c.wr_o, if_c.busy_o, if_c.done_o, if_c.err_o, if_c.err_code_o}),
            32'({3'b000, 1'b1, 1'b0, 1'b1, 2'b01}));
        if_c.wr_i = 1'b0;
        tick();
        chk("oor_release", 32'({if_c.busy_o, if_c.err_o, if_c.err_code_o}), 32'({1'b0, 1'b1, 2'b01}));
        if_c.err_clr_i = 1'b1;
        tick();
        if_c.err_clr_i = 1'b0;
        chk("oor_clear", 32'({if_c.err_o, if_c.err_code_o}), 32'h0);

        // Timeout: strobe held exactly 15 cycles, then error 10, no done
        issue_sel1(0, 0, hi, dones);
        chk("tmo_strobe_cycles", 32'(hi), 32'd15);
        chk("tmo_no_done", 32'(dones), 32'd0);
        chk("tmo_err", 32'({if_a.wr_o, if_a.busy_o, if_a.err_o, if_a.err_code_o}),
            32'({4'b0000, 1'b0, 1'b1, 2'b10}));
        if_a.err_clr_i = 1'b1;
        tick();
        if_a.err_clr_i = 1'b0;
        chk("tmo_clear", 32'({if_a.err_o, if_a.err_code_o}), 32'h0);

        // Clear on the timeout edge: the new error wins
        issue_sel1(15, 0, hi, dones);
        chk("race_strobe_cycles", 32'(hi), 32'd15);
        chk("race_err", 32'({if_a.err_o, if_a.err_code_o}), 32'({1'b1, 2'b10}));

        // Async reset mid-ISSUE drops strobe and error immediately
        if_a.wr_i = 1'b1; if_a.reg_sel_i = 2'd0; if_a.data_i = 8'h42;
        tick();
        if_a.wr_i = 1'b0;
        chk("pre_reset_strobe", 32'(if_a.wr_o), 32'b0001);
        #2 rst = 1'b1;
        #1;
        chk("async_reset", out_a(), 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        tick();
        chk("post_reset_idle", out_a(), 32'h0);
        if_a.wr_i = 1'b1; if_a.reg_sel_i = 2'd2; if_a.data_i = 8'h99;
        tick();
        if_a.wr_i = 1'b0;
        chk("post_reset_write", 32'({if_a.wr_o, if_a.data_o, if_a.busy_o}), 32'({4'b0100, 8'h99, 1'b1}));
        if_a.ack_i = 4'b0100;
        tick();
        if_a.ack_i = '0;
        chk("post_reset_done", 32'({if_a.wr_o, if_a.busy_o, if_a.done_o}), 32'({4'b0000, 1'b0, 1'b1}));
        tick();

        // Ack on the timeout edge counts as ack
        issue_sel1(0, 15, hi, dones);
        chk("ack15_strobe_cycles", 32'(hi), 32'd15);
        chk("ack15_done", 32'(dones), 32'd1);
        chk("ack15_no_err", 32'({if_a.wr_o, if_a.err_o, if_a.err_code_o}), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
